// File: rtl/dts_sar_ctrl.sv
// dts_sar_ctrl
//   Successive-approximation controller for the ECP3 digital temperature
//   sensor primitive. Drives a 4-bit trip-point code onto the primitive's
//   DTSI inputs and resolves the code bits MSB-first from the asynchronous
//   DTSO comparator output. Returns a 4-bit die-temperature code and a
//   registered over-temperature alarm.
//
// Parameters
//   SETTLE_CYCLES : clocks DTSI is held after each change before DTSO is
//                   sampled (SYNC_STAGES+1 .. 65535)
//   SYNC_STAGES   : synchroniser depth on DTSO (2 .. 3)
//
// Ports
//   CLK    in   system clock, all state on the rising edge
//   RSTN   in   asynchronous active-low reset
//   START  in   conversion request, sampled only while idle
//   ALMTH  in   [3:0] alarm threshold code (unsigned)
//   DTSO   in   sensor comparator, 1 = die temperature >= DTSI code (async)
//   DTSI   out  [3:0] trip-point code to the sensor (registered)
//   BUSY   out  conversion in progress
//   DONE   out  one-clock pulse when TCODE has just updated
//   TCODE  out  [3:0] last completed conversion result
//   VALID  out  at least one conversion completed since reset
//   ALARM  out  registered VALID && (TCODE >= ALMTH)

module dts_sar_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       START,
    input  logic [3:0] ALMTH,
    input  logic       DTSO,
    output logic [3:0] DTSI,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] TCODE,
    output logic       VALID,
    output logic       ALARM
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [15:0] CNT_RELOAD = 16'(SETTLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dtso_s;

    logic [1:0]  state_q, state_d;
    logic [3:0]  dtsi_q,  dtsi_d;
    logic [3:0]  res_q,   res_d;
    logic [1:0]  idx_q,   idx_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [3:0]  tcode_q, tcode_d;
    logic        valid_q, valid_d;
    logic        alarm_q;

    // DTSO is asynchronous to CLK; only the last stage is ever looked at.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop
            // samples pre-edge values regardless of statement order.
            sync_q <= {sync_q[SYNC_STAGES-2:0], DTSO};
        end
    end

    assign dtso_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d = state_q;
        dtsi_d  = dtsi_q;
        res_d   = res_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tcode_d = tcode_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                dtsi_d = 4'b0000;
                busy_d = 1'b0;
                if (START) begin
                    dtsi_d  = 4'b1000;
                    res_d   = 4'b0000;
                    idx_d   = 2'd3;
                    cnt_d   = CNT_RELOAD;
                    busy_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end

            // Counter holds at zero for the one clock that moves to SAMPLE,
            // so each trial code is on DTSI for SETTLE_CYCLES+1 clocks.
            ST_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            ST_SAMPLE: begin
                res_d[idx_q] = dtso_s;
                if (idx_q != 2'd0) begin
                    // Next trial keeps the resolved upper bits and sets the
                    // next bit down; lower bits of res_d are still zero.
                    dtsi_d  = res_d | (4'b0001 << (idx_q - 2'd1));
                    idx_d   = idx_q - 2'd1;
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SETTLE;
                end else begin
                    // Outputs are registered on entry so they are visible
                    // during the FINISH clock itself.
                    tcode_d = res_d;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    dtsi_d  = 4'b0000;
                    busy_d  = 1'b0;
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            dtsi_q  <= 4'b0000;
            res_q   <= 4'b0000;
            idx_q   <= 2'd3;
            cnt_q   <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tcode_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dtsi_q  <= dtsi_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tcode_q <= tcode_d;
            valid_q <= valid_d;
        end
    end

    // Re-evaluated every clock from the registered result, so it trails
    // TCODE/VALID and ALMTH changes by one clock.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= valid_q && (tcode_q >= ALMTH);
        end
    end

    assign DTSI  = dtsi_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign TCODE = tcode_q;
    assign VALID = valid_q;
    assign ALARM = alarm_q;

endmodule

// File: tb/tb_dts_sar_ctrl.sv
// tb_dts_sar_ctrl
//   Self-checking bench for dts_sar_ctrl. Two instances: 'a' with default
//   parameters and 'b' with SETTLE_CYCLES=3. A behavioural sensor drives
//   DTSO = (temp >= DTSI) unless stuck at 0. Expected results come from the
//   binary-search definition: the result equals the temperature, and the
//   n-th trial code is the result's top n bits with bit (3-n) set.

module tb_dts_sar_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] almth = 4'd0;
    logic [3:0] temp = 4'd0;
    logic       stuck0 = 1'b0;

    logic       start_a, start_b, dtso_a, dtso_b;
    logic [3:0] dtsi_a, dtsi_b, tcode_a, tcode_b;
    logic       busy_a, busy_b, done_a, done_b, valid_a, valid_b, alarm_a, alarm_b;

    logic [3:0] m_dtsi, m_tcode;
    logic       m_busy, m_done, m_valid, m_alarm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign dtso_a  = ~stuck0 && (temp >= dtsi_a);
    assign dtso_b  = ~stuck0 && (temp >= dtsi_b);

    assign m_dtsi  = sel ? dtsi_b  : dtsi_a;
    assign m_tcode = sel ? tcode_b : tcode_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_alarm = sel ? alarm_b : alarm_a;

    dts_sar_ctrl u_dut_a (
        .CLK(clk), .RSTN(rst_n), .START(start_a), .ALMTH(almth), .DTSO(dtso_a),
        .DTSI(dtsi_a), .BUSY(busy_a), .DONE(done_a), .TCODE(tcode_a),
        .VALID(valid_a), .ALARM(alarm_a)
    );

    dts_sar_ctrl #(.SETTLE_CYCLES(3), .SYNC_STAGES(2)) u_dut_b (
        .CLK(clk), .RSTN(rst_n), .START(start_b), .ALMTH(almth), .DTSO(dtso_b),
        .DTSI(dtsi_b), .BUSY(busy_b), .DONE(done_b), .TCODE(tcode_b),
        .VALID(valid_b), .ALARM(alarm_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full conversion on the selected instance, checked clock by clock.
    task automatic conv(input logic [3:0] t, input logic stk, input logic use_b,
                        input logic pulses);
        int sc, lat, res, n, exp_tr, k, done_at, bad_dtsi, busy_low;
        sc  = use_b ? 3 : 16;
        lat = 4 * (sc + 1);
        res = stk ? 0 : int'(t);
        @(negedge clk);
        sel = use_b; temp = t; stuck0 = stk; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; done_at = -1; bad_dtsi = 0; busy_low = 0;
        // Sample k is taken half a clock after edge k (edge 0 accepted START).
        while (done_at < 0 && k < 400) begin
            if (m_done) begin
                done_at = k;
            end else begin
                if (k < lat) begin
                    n = k / (sc + 1);
                    exp_tr = ((res >> (4 - n)) << (4 - n)) | (8 >> n);
                    if (32'(m_dtsi) !== 32'(exp_tr)) bad_dtsi++;
                end
                if (!m_busy) busy_low++;
            end
            start = pulses && (k == 5 || k == 20 || k == 40);
            k++;
            if (done_at < 0) @(negedge clk);
        end
        start = 1'b0;
        check("done_latency", 32'(done_at), 32'(lat));
        check("dtsi_trace_errs", 32'(bad_dtsi), 32'd0);
        check("busy_gaps", 32'(busy_low), 32'd0);
        check("tcode", 32'(m_tcode), 32'(res));
        check("valid", 32'(m_valid), 32'd1);
        check("busy_at_done", 32'(m_busy), 32'd0);
        check("dtsi_at_done", 32'(m_dtsi), 32'd0);
        @(negedge clk);
        check("done_width", 32'(m_done), 32'd0);
        check("alarm_after", 32'(m_alarm), 32'(res >= int'(almth)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dtsi"},  32'(dtsi_a),  32'd0);
        check({tag, "_busy"},  32'(busy_a),  32'd0);
        check({tag, "_done"},  32'(done_a),  32'd0);
        check({tag, "_tcode"}, 32'(tcode_a), 32'd0);
        check({tag, "_valid"}, 32'(valid_a), 32'd0);
        check({tag, "_alarm"}, 32'(alarm_a), 32'd0);
    endtask

    task automatic alarm_sweep_invalid();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            almth = 4'(a);
            @(negedge clk);
            check("alarm_before_valid", 32'(alarm_a), 32'd0);
        end
    endtask

    initial begin
        int dones, last, n, expt;
        logic [3:0] rt;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        alarm_sweep_invalid();

        // Basic conversion at temperature 9, then alarm behaviour.
        almth = 4'd10;
        conv(4'd9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("alarm_th10", 32'(alarm_a), 32'd0);
        almth = 4'd9;
        #1 check("alarm_not_comb", 32'(alarm_a), 32'd0);
        @(negedge clk);
        check("alarm_th9", 32'(alarm_a), 32'd1);
        almth = 4'd0;
        @(negedge clk);
        check("alarm_th0", 32'(alarm_a), 32'd1);

        // Extremes on the short-settle instance.
        conv(4'd15, 1'b0, 1'b1, 1'b0);
        conv(4'd7,  1'b1, 1'b1, 1'b0);
        conv(4'd0,  1'b0, 1'b1, 1'b0);

        // START pulses during a conversion must be ignored.
        conv(4'd6, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        sel = 1'b0; temp = 4'd9; stuck0 = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_idle_dtsi", 32'(dtsi_a), 32'd0);
        conv(4'd9, 1'b0, 1'b0, 1'b0);

        // START held: back-to-back conversions, temperature alternating.
        @(negedge clk);
        sel = 1'b0; stuck0 = 1'b0; temp = 4'd5; start = 1'b1;
        expt = 5; last = -1; n = 0;
        for (int k = 0; k < 600 && n < 4; k++) begin
            @(negedge clk);
            if (done_a) begin
                check("held_tcode", 32'(tcode_a), 32'(expt));
                if (last >= 0) check("held_period", 32'(k - last), 32'd70);
                last = k;
                n++;
                expt = (expt == 5) ? 11 : 5;
                temp = 4'(expt);
                if (n == 4) start = 1'b0;
            end
        end
        start = 1'b0;
        check("held_count", 32'(n), 32'd4);
        repeat (4) @(negedge clk);

        // Randomised conversions on both instances.
        repeat (8) begin
            rt = 4'($urandom_range(0, 15));
            almth = 4'($urandom_range(0, 15));
            conv(rt, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dts_sar_ctrl.md
# dts_sar_ctrl

Successive-approximation controller wrapped around the ECP3 digital temperature sensor primitive. It drives the 4-bit trip-point code on the primitive's DTSI3..DTSI0 inputs and consumes its asynchronous DTSO comparator output. It searches the four code bits MSB-first and returns a 4-bit die-temperature code plus a registered over-temperature alarm to system logic. It is the only block allowed to drive DTSI or read DTSO.

## Interface
- SETTLE_CYCLES, 16: clocks DTSI is held after each change before DTSO is sampled; legal range SYNC_STAGES+1..65535.
- SYNC_STAGES, 2: flop stages on DTSO before use; legal range 2..3.
- CLK  input  1  single system clock; all state on rising edge.
- RSTN  input  1  reset, asynchronous assert, active-low; deassertion is synchronised externally.
- START  input  1  request a conversion; sampled only in IDLE.
- ALMTH  input  4  alarm threshold code.
- DTSO  input  1  sensor comparator output, asynchronous; 1 means die temperature >= code currently on DTSI.
- DTSI  output  4  trip-point code to sensor (bit 3 -> DTSI3 ... bit 0 -> DTSI0); registered.
- BUSY  output  1  conversion in progress.
- DONE  output  1  one-clock pulse when TCODE has just updated.
- TCODE  output  4  last completed conversion result.
- VALID  output  1  at least one conversion has completed since reset.
- ALARM  output  1  registered VALID && (TCODE >= ALMTH).

## Operation
- Reset (RSTN=0, async): state IDLE, DTSI=0, BUSY=0, DONE=0, TCODE=0, VALID=0, ALARM=0, sync chain=0, bit index=3, settle counter=0.
- DTSO passes through SYNC_STAGES flops. Only the last stage, dtso_s, is used.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE: DTSI=0 and BUSY=0. If START=1, load DTSI=4'b1000, the working result to 0, bit index to 3 and the counter to SETTLE_CYCLES-1. Go to SETTLE with BUSY=1.
- SETTLE: the counter decrements every clock. When it is 0, go to SAMPLE.
- SAMPLE: the working result takes DTSI bit[idx]=dtso_s; the other bits keep their value. If idx>0, set DTSI = working result with bit[idx-1] set, decrement idx, reload the counter and go to SETTLE. If idx=0, go to FINISH.
- FINISH: TCODE = final result, VALID=1, DONE=1 for this clock only, DTSI=0, BUSY=0. Go to IDLE.
- START while BUSY: ignored, not queued. START held high runs back-to-back conversions, each beginning with the IDLE clock after FINISH.
- ALMTH is compared unsigned, and ALARM is re-registered every clock. An ALMTH change is reflected one clock later. ALMTH=0 gives ALARM=1 whenever VALID=1.
- Extremes: DTSO always 1 gives TCODE=15. DTSO always 0 gives TCODE=0. No special cases.
- Reset mid-conversion aborts immediately to the reset values above. No partial TCODE update and no DONE.

## Timing
- DTSI changes only on a clock edge. Each trial code is held exactly SETTLE_CYCLES+1 clocks (SETTLE plus SAMPLE).
- The sample for each bit uses dtso_s at the end of the trial's (SETTLE_CYCLES+1)th clock. SETTLE_CYCLES >= SYNC_STAGES+1 guarantees the sampled value reflects the current trial code.
- Latency: taking the START-accepting edge as edge 0, DONE is high during the clock following edge 4*(SETTLE_CYCLES+1). That is 69 clocks for the defaults.
- TCODE, VALID and BUSY=0 are visible in the same clock as DONE. ALARM follows one clock later.
- Throughput with START held: one conversion per 4*(SETTLE_CYCLES+1)+2 clocks, which is 70 for the defaults.

## Test plan
- Sensor model DTSO = (DTSI <= 9), START pulse, defaults. Required response:
  - DTSI sequence 8, 12, 10, 9, each held 17 clocks;
  - DONE one clock, 69 clocks after accept;
  - TCODE=9, VALID=1, DTSI back to 0.
- Extremes, SETTLE_CYCLES=3:
  - model temperature 15 -> DTSI 8, 12, 14, 15, TCODE=15;
  - model temperature 0 (DTSO stuck 0) -> TCODE=0.
- START pulsed at clocks 5, 20 and 40 of a conversion -> no restart, exactly one DONE, BUSY high continuously until FINISH.
- RSTN low for 1 clock at clock 30 of a conversion -> all outputs return to their reset values asynchronously, no DONE, and the next START gives a correct full conversion.
- Alarm with TCODE=9:
  - ALMTH=10 -> ALARM=0;
  - ALMTH changed to 9 -> ALARM=1 one clock later;
  - ALMTH=0 -> ALARM=1;
  - before the first conversion ALARM=0 for all ALMTH.
- START held high, model temperature toggling between 5 and 11 per conversion -> DONE every 70 clocks, TCODE alternating 5, 11.
